// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU: the 5-bit opcode encoding and the
// controller state type. No ports; imported by alu_comb and alu_seq.
// -----------------------------------------------------------------------------
package alu_pkg;

   // Opcodes 0-12 keep the encoding of the older 4-bit ALU; 17-31 act as ZERO.
   localparam logic [4:0] OP_ADD   = 5'd0;
   localparam logic [4:0] OP_SUB   = 5'd1;
   localparam logic [4:0] OP_AND   = 5'd2;
   localparam logic [4:0] OP_OR    = 5'd3;
   localparam logic [4:0] OP_NOR   = 5'd4;
   localparam logic [4:0] OP_XOR   = 5'd5;
   localparam logic [4:0] OP_XNOR  = 5'd6;
   localparam logic [4:0] OP_NAND  = 5'd7;
   localparam logic [4:0] OP_PASSA = 5'd8;
   localparam logic [4:0] OP_PASSB = 5'd9;
   localparam logic [4:0] OP_ZERO  = 5'd10;
   localparam logic [4:0] OP_SLT   = 5'd11;
   localparam logic [4:0] OP_SLTU  = 5'd12;
   localparam logic [4:0] OP_SLL   = 5'd13;
   localparam logic [4:0] OP_SRL   = 5'd14;
   localparam logic [4:0] OP_SRA   = 5'd15;
   localparam logic [4:0] OP_MUL   = 5'd16;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_MUL   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/alu_comb.sv
// -----------------------------------------------------------------------------
// alu_comb
// Purely combinational WIDTH-bit ALU core for opcodes 0-12.
//   i_op        : operation select (5-bit; anything outside 0-12 yields zero)
//   i_a, i_b    : operands
//   o_result    : operation result
//   o_carry     : carry out of the MSB (ADD/SUB only, else 0)
//   o_overflow  : signed overflow (ADD/SUB only, else 0)
// -----------------------------------------------------------------------------
module alu_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [4:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_result,
   output logic             o_carry,
   output logic             o_overflow
);

   localparam int M = WIDTH - 1;

   logic [WIDTH:0] w_add;
   logic [WIDTH:0] w_sub;
   logic           w_add_v;
   logic           w_sub_v;

   assign w_add = {1'b0, i_a} + {1'b0, i_b};
   // Subtract as a + ~b + 1 so the carry out means "no borrow".
   assign w_sub = {1'b0, i_a} + {1'b0, ~i_b} + {{WIDTH{1'b0}}, 1'b1};

   assign w_add_v = (i_a[M] == i_b[M]) && (w_add[M] != i_a[M]);
   assign w_sub_v = (i_a[M] != i_b[M]) && (w_sub[M] != i_a[M]);

   always_comb begin
      o_result   = '0;
      o_carry    = 1'b0;
      o_overflow = 1'b0;
      case (i_op)
         OP_ADD: begin
            o_result   = w_add[M:0];
            o_carry    = w_add[WIDTH];
            o_overflow = w_add_v;
         end
         OP_SUB: begin
            o_result   = w_sub[M:0];
            o_carry    = w_sub[WIDTH];
            o_overflow = w_sub_v;
         end
         OP_AND:   o_result = i_a & i_b;
         OP_OR:    o_result = i_a | i_b;
         OP_NOR:   o_result = ~(i_a | i_b);
         OP_XOR:   o_result = i_a ^ i_b;
         OP_XNOR:  o_result = ~(i_a ^ i_b);
         OP_NAND:  o_result = ~(i_a & i_b);
         OP_PASSA: o_result = i_a;
         OP_PASSB: o_result = i_b;
         // Signed less-than: true sign of (a - b) is sum MSB corrected by overflow.
         OP_SLT:   o_result = {{(WIDTH-1){1'b0}}, w_sub[M] ^ w_sub_v};
         // Unsigned less-than: a borrow occurred.
         OP_SLTU:  o_result = {{(WIDTH-1){1'b0}}, ~w_sub[WIDTH]};
         default:  o_result = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq
// Sequential WIDTH-bit ALU with valid/ready handshakes, iterative shifts
// (one bit per cycle) and a shift-add multiplier. Results and flags are
// registered and held while the consumer stalls.
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operation handshake (opcode, a, b captured on accept)
//   flush                : synchronous abort, back to idle, result discarded
//   out_valid / out_ready: result handshake
//   result, flag_c/v/z/n : registered result and status flags
// -----------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [4:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_v,
   output logic             flag_z,
   output logic             flag_n
);

   localparam int             M         = WIDTH - 1;
   localparam logic [SHW:0]   L_CNT_MUL = WIDTH[SHW:0];
   localparam logic [SHW:0]   L_CNT_ONE = {{SHW{1'b0}}, 1'b1};

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [SHW:0]     r_cnt;
   logic [4:0]       r_op;
   logic [WIDTH-1:0] r_result;
   logic             r_c;
   logic             r_v;
   logic             r_z;
   logic             r_n;

   logic             w_accept;
   logic             w_is_shift;
   logic [SHW-1:0]   w_shamt;
   logic [WIDTH-1:0] w_comb_result;
   logic             w_comb_c;
   logic             w_comb_v;
   logic [WIDTH-1:0] w_shift_one;
   logic [WIDTH-1:0] w_mul_sum;
   logic             w_load_en;
   logic [WIDTH-1:0] w_load_result;
   logic             w_load_c;
   logic             w_load_v;

   alu_comb #(.WIDTH(WIDTH)) u_comb (
      .i_op       (opcode),
      .i_a        (a),
      .i_b        (b),
      .o_result   (w_comb_result),
      .o_carry    (w_comb_c),
      .o_overflow (w_comb_v)
   );

   assign in_ready   = (r_state == S_IDLE) && !flush;
   assign w_accept   = in_valid && in_ready;
   assign w_is_shift = (opcode == OP_SLL) || (opcode == OP_SRL) || (opcode == OP_SRA);
   assign w_shamt    = b[SHW-1:0];

   // One-bit step of the in-flight shift; direction comes from the captured opcode.
   always_comb begin
      case (r_op)
         OP_SLL:  w_shift_one = {r_acc[M-1:0], 1'b0};
         OP_SRA:  w_shift_one = {r_acc[M], r_acc[M:1]};
         default: w_shift_one = {1'b0, r_acc[M:1]};
      endcase
   end

   assign w_mul_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Next state; flush overrides every other condition.
   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  if (opcode == OP_MUL)
                     w_state_next = S_MUL;
                  else if (w_is_shift && (w_shamt != '0))
                     w_state_next = S_SHIFT;
                  else
                     w_state_next = S_DONE;
               end
            end
            S_SHIFT: if (r_cnt == L_CNT_ONE) w_state_next = S_DONE;
            S_MUL:   if (r_cnt == L_CNT_ONE) w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
         endcase
      end
   end

   // Value captured into the output registers on the way into DONE.
   always_comb begin
      w_load_en     = 1'b0;
      w_load_result = w_comb_result;
      w_load_c      = w_comb_c;
      w_load_v      = w_comb_v;
      case (r_state)
         S_IDLE: begin
            if (w_accept && (opcode != OP_MUL) && !(w_is_shift && (w_shamt != '0))) begin
               w_load_en = 1'b1;
               if (w_is_shift) begin
                  w_load_result = a;  // zero-distance shift
                  w_load_c      = 1'b0;
                  w_load_v      = 1'b0;
               end
            end
         end
         S_SHIFT: begin
            w_load_en     = !flush && (r_cnt == L_CNT_ONE);
            w_load_result = w_shift_one;
            w_load_c      = 1'b0;
            w_load_v      = 1'b0;
         end
         S_MUL: begin
            w_load_en     = !flush && (r_cnt == L_CNT_ONE);
            w_load_result = w_mul_sum;
            w_load_c      = 1'b0;
            w_load_v      = 1'b0;
         end
         default: w_load_en = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
         r_op     <= '0;
         r_result <= '0;
         r_c      <= 1'b0;
         r_v      <= 1'b0;
         r_z      <= 1'b0;
         r_n      <= 1'b0;
      end else begin
         r_state <= w_state_next;
         if (w_load_en) begin
            r_result <= w_load_result;
            r_c      <= w_load_c;
            r_v      <= w_load_v;
            r_z      <= (w_load_result == '0);
            r_n      <= w_load_result[M];
         end
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_op     <= opcode;
                  r_acc    <= (opcode == OP_MUL) ? '0 : a;
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_cnt    <= (opcode == OP_MUL) ? L_CNT_MUL : {1'b0, w_shamt};
               end
            end
            S_SHIFT: begin
               r_acc <= w_shift_one;
               r_cnt <= r_cnt - L_CNT_ONE;
            end
            S_MUL: begin
               // Bits shifted past the MSB are dropped: product is modulo 2^WIDTH.
               r_acc    <= w_mul_sum;
               r_mcand  <= {r_mcand[M-1:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[M:1]};
               r_cnt    <= r_cnt - L_CNT_ONE;
            end
            default: ;
         endcase
      end
   end

   assign out_valid = (r_state == S_DONE);
   assign result    = r_result;
   assign flag_c    = r_c;
   assign flag_v    = r_v;
   assign flag_z    = r_z;
   assign flag_n    = r_n;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq
// Scoreboard bench for alu_seq (WIDTH=32). The driver pushes the expected
// result, flags and latency computed by a behavioural model; a monitor pops
// and compares on every output handshake and checks hold/busy behaviour.
// -----------------------------------------------------------------------------
module tb_alu_seq;
   import alu_pkg::*;

   typedef struct {
      logic [31:0] r;
      logic        c, v, z, n;
      int          lat;
      int          acc;
      logic [4:0]  op;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  opcode = 5'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        flag_c, flag_v, flag_z, flag_n;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
   exp_t sb[$];

   alu_seq #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .flag_c(flag_c), .flag_v(flag_v),
      .flag_z(flag_z), .flag_n(flag_n)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Reference model: plain arithmetic on whole words.
   function automatic exp_t model(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      exp_t               e;
      longint             sx;
      longint             sy;
      logic [32:0]        w;
      logic signed [31:0] t;
      int                 sh;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sh = int'(y[4:0]);
      t  = x;
      e.r = 32'd0; e.c = 1'b0; e.v = 1'b0; e.lat = 1; e.acc = 0; e.op = op;
      case (op)
         OP_ADD: begin
            w = {1'b0, x} + {1'b0, y};
            e.r = w[31:0]; e.c = w[32];
            e.v = ((sx + sy) != longint'($signed(e.r)));
         end
         OP_SUB: begin
            e.r = x - y; e.c = (x >= y);
            e.v = ((sx - sy) != longint'($signed(e.r)));
         end
         OP_AND:   e.r = x & y;
         OP_OR:    e.r = x | y;
         OP_NOR:   e.r = ~(x | y);
         OP_XOR:   e.r = x ^ y;
         OP_XNOR:  e.r = ~(x ^ y);
         OP_NAND:  e.r = ~(x & y);
         OP_PASSA: e.r = x;
         OP_PASSB: e.r = y;
         OP_SLT:   e.r = (sx < sy) ? 32'd1 : 32'd0;
         OP_SLTU:  e.r = (x < y) ? 32'd1 : 32'd0;
         OP_SLL: begin e.r = x << sh; e.lat = sh + 1; end
         OP_SRL: begin e.r = x >> sh; e.lat = sh + 1; end
         OP_SRA: begin e.r = t >>> sh; e.lat = sh + 1; end
         OP_MUL: begin e.r = x * y; e.lat = 33; end
         default: e.r = 32'd0;
      endcase
      e.z = (e.r == 32'd0);
      e.n = e.r[31];
      return e;
   endfunction

   // Present one operation, hold until accepted, then scramble the inputs.
   task automatic issue(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
      int   n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("issue_timeout", 64'(in_ready), 64'd1);
      end else begin
         opcode = op; a = x; b = y; in_valid = 1'b1;
         e = model(op, x, y);
         e.acc = cyc;
         sb.push_back(e);
         @(negedge clk);
         in_valid = 1'b0;
         opcode = 5'($urandom_range(0, 31));
         a = $urandom;
         b = $urandom;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (sb.size() > 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() > 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   // Monitor
   logic        prev_valid = 1'b0;
   logic        prev_hold = 1'b0;
   logic [36:0] held = '0;
   exp_t        mon_e;

   always @(negedge clk) begin
      if (prev_hold)
         chk("hold_stable", 64'({out_valid, result, flag_c, flag_v, flag_z, flag_n}), 64'(held));
      if (out_valid && !prev_valid) begin
         if (sb.size() == 0)
            chk("unexpected_out_valid", 64'(out_valid), 64'd0);
         else
            chk($sformatf("latency_op%0d", sb[0].op), 64'(cyc - sb[0].acc), 64'(sb[0].lat));
      end
      if (sb.size() > 0 && sb[0].acc < cyc)
         chk("busy_in_ready", 64'(in_ready), 64'd0);
      case (rdy_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 2) != 0);
         default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready && sb.size() > 0) begin
         mon_e = sb.pop_front();
         $display("[TB] op=%0d result=0x%08h flags(cvzn)=%b%b%b%b", mon_e.op, result,
                  flag_c, flag_v, flag_z, flag_n);
         chk($sformatf("result_op%0d", mon_e.op), 64'(result), 64'(mon_e.r));
         chk($sformatf("flags_op%0d", mon_e.op), 64'({flag_c, flag_v, flag_z, flag_n}),
             64'({mon_e.c, mon_e.v, mon_e.z, mon_e.n}));
      end
      prev_hold  = out_valid && !out_ready;
      held       = {out_valid, result, flag_c, flag_v, flag_z, flag_n};
      prev_valid = out_valid;
   end

   initial begin
      logic [4:0]  op;
      logic [31:0] x;
      logic [31:0] y;

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_result", 64'(result), 64'd0);
      chk("reset_flags", 64'({flag_c, flag_v, flag_z, flag_n}), 64'd0);
      chk("reset_in_ready", 64'(in_ready), 64'd1);

      // Directed cases
      rdy_mode = 0;
      issue(OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001);
      issue(OP_SUB,  32'd5, 32'd5);
      issue(OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001);
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001);
      issue(OP_SRA,  32'h8000_0000, 32'd4);
      issue(OP_SLL,  32'hDEAD_BEEF, 32'd0);
      issue(OP_MUL,  32'h0001_0003, 32'h0001_0005);
      issue(OP_SRL,  32'hF000_0001, 32'd31);
      issue(5'd20,   32'h1234_5678, 32'h1);
      wait_idle();

      // Consumer stall in DONE
      rdy_mode = 2;
      issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'd0);
      end
      #1 rdy_mode = 0;
      @(negedge clk);
      @(negedge clk);
      #1 chk("release_in_ready", 64'(in_ready), 64'd1);

      // Randomised traffic with random back-pressure
      rdy_mode = 1;
      for (int i = 0; i < 150; i++) begin
         op = 5'($urandom_range(0, 31));
         x  = $urandom;
         y  = $urandom;
         if ((op >= OP_SLL) && (op <= OP_SRA) && ($urandom_range(0, 1) == 0))
            y = 32'($urandom_range(0, 3));
         issue(op, x, y);
      end
      wait_idle();
      rdy_mode = 0;

      // Flush mid-multiply together with a new request
      issue(OP_MUL, 32'h0000_0003, 32'h0000_0005);
      repeat (9) @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; opcode = OP_ADD; a = 32'd1; b = 32'd2;
      sb.delete();
      #1 chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      #1 chk("flush_idle", 64'(in_ready), 64'd1);
      repeat (40) @(negedge clk);

      // Asynchronous reset in the middle of a shift
      issue(OP_ADD, 32'h0000_1234, 32'h0000_0001);
      wait_idle();
      issue(OP_SRL, 32'hFFFF_0000, 32'd20);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'd0);
      chk("arst_result", 64'(result), 64'd0);
      chk("arst_flags", 64'({flag_c, flag_v, flag_z, flag_n}), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("arst_in_ready", 64'(in_ready), 64'd1);
      issue(OP_XOR, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
      wait_idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised WIDTH-bit ALU and the successor of the 1-bit slice ALU.
- Keeps the existing 4-bit operation codes 0-12 and widens the opcode to 5 bits.
- Adds iterative shifts and a shift-add multiply, both multi-cycle, plus status flags.
- Registered outputs with a valid/ready handshake on input and output; sits between decode and writeback in the CPU datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two and >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/opcode valid.
- in_ready  out  1  block can accept a new operation.
- opcode  in  5  operation select.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; b[SHW-1:0] is the shift amount for shifts.
- flush  in  1  synchronous abort of the operation in progress.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operation result.
- flag_c  out  1  carry out of MSB (ADD/SUB only).
- flag_v  out  1  signed overflow (ADD/SUB only).
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB (a + ~b + 1), 2 AND, 3 OR, 4 NOR, 5 XOR, 6 XNOR, 7 NAND.
  - 8 PASSA, 9 PASSB, 10 ZERO.
  - 11 SLT (signed, via sum MSB ^ overflow), 12 SLTU (~carry of a - b).
  - 13 SLL, 14 SRL, 15 SRA, 16 MUL (low WIDTH bits, unsigned shift-add).
  - 17-31 behave as ZERO.
- SLT/SLTU result is zero-extended 0 or 1.
- flag_c and flag_v are 0 for every op except ADD/SUB. For SUB, flag_c = 1 means no borrow.
- flag_z and flag_n are derived from the final result for all ops.
- FSM states: IDLE, SHIFT, MUL, DONE.
- in_ready = (state == IDLE) && !flush. An accept is in_valid && in_ready.
- IDLE transitions on accept:
  - Single-cycle op (0-12, 17-31), or a shift with shamt == 0 -> DONE next edge, with result/flags registered.
  - Shift with shamt > 0 -> SHIFT. Load the accumulator with a and a counter with shamt.
  - MUL -> MUL. Clear the accumulator, load the multiplicand with a, the multiplier with b, and the counter with WIDTH.
- SHIFT: shift the accumulator 1 bit per cycle (SRA replicates the MSB) and decrement the counter. When the counter reaches 1, go to DONE.
  - Latency from accept to out_valid = shamt + 1 cycles.
- MUL: each cycle, if multiplier[0] then acc += multiplicand. Then multiplicand <<= 1 and multiplier >>= 1; discard overflow beyond WIDTH. After WIDTH iterations, go to DONE.
  - Latency = WIDTH + 1.
- DONE: out_valid = 1. result/flags are held stable while out_valid && !out_ready. out_valid && out_ready -> IDLE next edge.
  - Back-to-back throughput for single-cycle ops is one per 2 cycles.
- flush = 1 at any state -> IDLE next edge, out_valid = 0, and any pending result is discarded. flush wins over a simultaneous in_valid or out_ready.
- Operands are captured at accept. Changes to a/b/opcode while busy have no effect.
- Reset (async, any state) -> IDLE, with out_valid = 0, result = 0, and all flags = 0.
  - in_ready is 1 immediately after reset deasserts, unless flush is asserted.
- Arithmetic wraps modulo 2^WIDTH. No exceptions are raised.

Decomposition:
- alu_pkg holds:
  - opcode localparams OP_ADD..OP_MUL (5-bit);
  - the state typedef/localparams S_IDLE, S_SHIFT, S_MUL, S_DONE.
- Sub-module alu_comb: purely combinational WIDTH-bit core for opcodes 0-12.
  - Outputs result, carry and overflow.
  - alu_seq instantiates it for single-cycle ops and owns the FSM, counter, shift/MUL datapath and output registers.

Test Plan:
- WIDTH=32, ADD a=0x7FFFFFFF b=1, out_ready=1 -> out_valid one cycle after accept; result 0x80000000, c=0, v=1, n=1, z=0.
- SUB a=5 b=5 -> result 0, c=1, z=1. SLT a=0xFFFFFFFF(-1) b=1 -> result 1. SLTU with the same operands -> result 0.
- SRA a=0x80000000 b=4 -> out_valid 5 cycles after accept, result 0xF8000000. SLL with b=0 -> latency 1, result = a.
- MUL a=0x0001_0003 b=0x0001_0005 -> out_valid after 33 cycles, result 0x0008_000F (low 32 bits). in_ready stays 0 throughout.
- Hold out_ready=0 for 5 cycles in DONE -> result/flags stable and in_ready=0. Then pulse out_ready -> IDLE, in_ready=1 next cycle.
- Assert flush mid-MUL (cycle 10) together with in_valid -> no accept, out_valid never rises, IDLE next cycle. Assert rst_n=0 mid-SHIFT -> outputs 0 immediately.
